// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with a small write FIFO: start bit, LSB-first data,
// optional parity, 1-2 stop bits; queued words go out back-to-back.
module uart_tx_framed #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_L,
    input  logic                        i_Tx_DV,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Overflow,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Done
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 ready_q, ready_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head_c;
    logic                 wr_en_c, pop_c, bit_end_c, fifo_empty_c;

    assign wr_en_c      = i_Tx_DV & ready_q;
    assign head_c       = mem_q[rd_ptr_q];
    assign fifo_empty_c = (count_q == '0);
    assign bit_end_c    = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));

    // FIFO bookkeeping; ready is registered from the next count so it always tracks count_q
    always_comb begin
        wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
        ovf_d    = i_Tx_DV & ~ready_q;
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // Frame sequencer; the line is registered from state_q, so it trails the FSM by one clock
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        pop_c     = 1'b0;
        serial_d  = 1'b1;
        active_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c = 1'b1;
                end
            end
            S_START: begin
                serial_d  = 1'b0;
                active_d  = 1'b1;
                clk_cnt_d = clk_cnt_q + CLK_W'(1);
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                serial_d  = shift_q[0];
                active_d  = 1'b1;
                clk_cnt_d = clk_cnt_q + CLK_W'(1);
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                serial_d  = parity_q;
                active_d  = 1'b1;
                clk_cnt_d = clk_cnt_q + CLK_W'(1);
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                active_d  = 1'b1;
                clk_cnt_d = clk_cnt_q + CLK_W'(1);
                if (bit_end_c) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        pop_c     = !fifo_empty_c;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        if (pop_c) begin
            shift_d   = head_c;
            parity_d  = (PARITY_MODE == 1) ? ~(^head_c) : (^head_c);
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = S_START;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign o_Tx_Ready   = ready_q;
    assign o_Fifo_Count = count_q;
    assign o_Overflow   = ovf_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Serial  = serial_q;
    assign o_Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: three parameterisations side by side, line history
// recorded every cycle and compared against a frame-level reference model.
module tb_uart_tx_framed;
    localparam int HIST = 20000;

    typedef struct {
        logic       dv;
        logic [8:0] data;
        logic [2:0] exp_cnt;
        logic       exp_ready;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n;
    logic [2:0] dv;
    logic [7:0] din0, din2;
    logic [6:0] din1;
    logic       ser0, ser1, ser2, act0, act1, act2, dn0, dn1, dn2;
    logic       ovf0, ovf1, ovf2, rdy0, rdy1, rdy2;
    logic [2:0] cnt0, cnt1, cnt2;
    logic [2:0] serial, active, done, ovf, ready;

    assign serial = {ser2, ser1, ser0};
    assign active = {act2, act1, act0};
    assign done   = {dn2, dn1, dn0};
    assign ovf    = {ovf2, ovf1, ovf0};
    assign ready  = {rdy2, rdy1, rdy0};

    int cpb [3] = '{16, 16, 16};
    int db  [3] = '{8, 7, 8};
    int pm  [3] = '{2, 1, 0};
    int sb  [3] = '{1, 2, 1};

    uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_Clock(clk), .i_Rst_L(rst_n[0]), .i_Tx_DV(dv[0]), .i_Tx_Byte(din0),
        .o_Tx_Ready(rdy0), .o_Fifo_Count(cnt0), .o_Overflow(ovf0),
        .o_Tx_Active(act0), .o_Tx_Serial(ser0), .o_Tx_Done(dn0));

    uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .i_Clock(clk), .i_Rst_L(rst_n[1]), .i_Tx_DV(dv[1]), .i_Tx_Byte(din1),
        .o_Tx_Ready(rdy1), .o_Fifo_Count(cnt1), .o_Overflow(ovf1),
        .o_Tx_Active(act1), .o_Tx_Serial(ser1), .o_Tx_Done(dn1));

    uart_tx_framed #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_Clock(clk), .i_Rst_L(rst_n[2]), .i_Tx_DV(dv[2]), .i_Tx_Byte(din2),
        .o_Tx_Ready(rdy2), .o_Fifo_Count(cnt2), .o_Overflow(ovf2),
        .o_Tx_Active(act2), .o_Tx_Serial(ser2), .o_Tx_Done(dn2));

    int n_checks = 0;
    int n_fail   = 0;

    // cyc counts rising edges; history slot c holds outputs as they stood after edge c
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic hs [3][HIST];
    logic ha [3][HIST];
    logic hd [3][HIST];
    always @(negedge clk) begin
        if (cyc < HIST) begin
            for (int k = 0; k < 3; k++) begin
                hs[k][cyc] = serial[k];
                ha[k][cyc] = active[k];
                hd[k][cyc] = done[k];
            end
        end
    end

    logic [8:0] wq[$];

    function automatic logic [2:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [8:0] w);
        dv[k] = v;
        case (k)
            0:       din0 = w[7:0];
            1:       din1 = w[6:0];
            default: din2 = w[7:0];
        endcase
    endtask

    // Called at a falling edge; acc is the rising edge that takes the word
    task automatic write_word(input int k, input logic [8:0] w, output int acc);
        drive(k, 1'b1, w);
        acc = cyc + 1;
        @(negedge clk);
        drive(k, 1'b0, w);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((active[k] !== 1'b0 || get_cnt(k) !== 3'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout u%0d", k);
        end
    endtask

    // Bit n of a frame (0 = start) from the framing rules
    function automatic logic frame_bit(input int k, input logic [8:0] w, input int n);
        logic par;
        par = 1'b0;
        for (int i = 0; i < db[k]; i++) par = par ^ w[i];
        if (n == 0) return 1'b0;
        if (n <= db[k]) return w[n-1];
        if (pm[k] != 0 && n == db[k] + 1) return (pm[k] == 1) ? ~par : par;
        return 1'b1;
    endfunction

    // Expected line/active/done for nw contiguous frames of wq whose first line-low cycle is s
    task automatic check_stream(input int k, input int s, input int nw);
        int total, t_end, rel, pos;
        logic es, ea, ed;
        int bs, ba, bd;
        logic gs, ws, ga, wa, gd, wd;
        total = cpb[k] * (1 + db[k] + ((pm[k] != 0) ? 1 : 0) + sb[k]);
        t_end = s + nw * total + 4;
        while (cyc <= t_end) @(negedge clk);
        bs = -1; ba = -1; bd = -1;
        gs = 0; ws = 0; ga = 0; wa = 0; gd = 0; wd = 0;
        for (int t = s - 1; t <= t_end; t++) begin
            rel = t - s;
            if (rel < 0 || rel >= nw * total) begin
                es = 1'b1; ea = 1'b0; ed = 1'b0;
            end else begin
                pos = rel % total;
                es  = frame_bit(k, wq[rel / total], pos / cpb[k]);
                ea  = 1'b1;
                ed  = (pos == total - 1);
            end
            if (hs[k][t] !== es && bs < 0) begin bs = t; gs = hs[k][t]; ws = es; end
            if (ha[k][t] !== ea && ba < 0) begin ba = t; ga = ha[k][t]; wa = ea; end
            if (hd[k][t] !== ed && bd < 0) begin bd = t; gd = hd[k][t]; wd = ed; end
        end
        n_checks += 3;
        if (bs >= 0) begin n_fail++; $display("FAIL stream_serial u%0d cycle=%0d got=%b want=%b", k, bs - s, gs, ws); end
        if (ba >= 0) begin n_fail++; $display("FAIL stream_active u%0d cycle=%0d got=%b want=%b", k, ba - s, ga, wa); end
        if (bd >= 0) begin n_fail++; $display("FAIL stream_done u%0d cycle=%0d got=%b want=%b", k, bd - s, gd, wd); end
    endtask

    task automatic count_window(input int k, input int lo, input int hi, output int n_act, output int n_done);
        n_act = 0;
        n_done = 0;
        for (int t = lo; t <= hi; t++) begin
            if (ha[k][t] === 1'b1) n_act++;
            if (hd[k][t] === 1'b1) n_done++;
        end
    endtask

    initial begin
        vec_t       vecs [6];
        logic [10:0] a5_exp, z_exp;
        int         a, b, s, dummy, n_act, n_done, prev, gaps_ok, n, t;
        logic [8:0] mask, w;

        vecs[0] = '{dv: 1'b1, data: 9'h011, exp_cnt: 3'd1, exp_ready: 1'b1, exp_ovf: 1'b0};
        vecs[1] = '{dv: 1'b1, data: 9'h022, exp_cnt: 3'd2, exp_ready: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{dv: 1'b1, data: 9'h033, exp_cnt: 3'd3, exp_ready: 1'b1, exp_ovf: 1'b0};
        vecs[3] = '{dv: 1'b1, data: 9'h044, exp_cnt: 3'd4, exp_ready: 1'b0, exp_ovf: 1'b0};
        vecs[4] = '{dv: 1'b1, data: 9'h055, exp_cnt: 3'd4, exp_ready: 1'b0, exp_ovf: 1'b1};
        vecs[5] = '{dv: 1'b0, data: 9'h000, exp_cnt: 3'd4, exp_ready: 1'b0, exp_ovf: 1'b0};
        a5_exp = 11'b10101001010;
        z_exp  = 11'b11100000000;

        rst_n = 3'b000;
        dv    = 3'b000;
        din0  = '0;
        din1  = '0;
        din2  = '0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_serial_u%0d", k), 32'(serial[k]), 32'd1);
            chk($sformatf("rst_active_u%0d", k), 32'(active[k]), 32'd0);
            chk($sformatf("rst_done_u%0d", k),   32'(done[k]),   32'd0);
            chk($sformatf("rst_ovf_u%0d", k),    32'(ovf[k]),    32'd0);
            chk($sformatf("rst_ready_u%0d", k),  32'(ready[k]),  32'd1);
            chk($sformatf("rst_cnt_u%0d", k),    32'(get_cnt(k)), 32'd0);
        end
        rst_n = 3'b111;
        @(negedge clk);

        // 0xA5, 8 data bits, even parity, one stop bit
        wq = {9'h0A5};
        write_word(0, 9'h0A5, a);
        s = a + 2;
        check_stream(0, s, 1);
        for (int i = 0; i < 11; i++) chk($sformatf("a5_bit%0d", i), 32'(hs[0][s + i*16 + 8]), 32'(a5_exp[i]));
        chk("a5_first_low", 32'(hs[0][s]), 32'd0);
        chk("a5_line_high_before", 32'(hs[0][s-1]), 32'd1);
        count_window(0, a, s + 180, n_act, n_done);
        chk("a5_active_clocks", 32'(n_act), 32'd176);
        chk("a5_done_pulses", 32'(n_done), 32'd1);
        wait_idle(0);

        // 0x00, 7 data bits, odd parity, two stop bits
        wq = {9'h000};
        write_word(1, 9'h000, a);
        s = a + 2;
        check_stream(1, s, 1);
        for (int i = 0; i < 11; i++) chk($sformatf("z_bit%0d", i), 32'(hs[1][s + i*16 + 8]), 32'(z_exp[i]));
        n = 0;
        for (int i = 0; i < 32; i++) if (hs[1][s + 144 + i] === 1'b1) n++;
        chk("z_stop_high_clocks", 32'(n), 32'd32);
        count_window(1, a, s + 180, n_act, n_done);
        chk("z_frame_clocks", 32'(n_act), 32'd176);
        chk("z_done_pulses", 32'(n_done), 32'd1);
        wait_idle(1);

        // Fill the FIFO behind a frame already on the line, then overflow it
        write_word(2, 9'h0E7, a);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drive(2, vecs[i].dv, vecs[i].data);
            @(negedge clk);
            chk($sformatf("vec%0d_cnt", i),   32'(cnt2), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ready", i), 32'(rdy2), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_ovf", i),   32'(ovf2), 32'(vecs[i].exp_ovf));
        end
        drive(2, 1'b0, 9'h000);
        wq = {9'h0E7, 9'h011, 9'h022, 9'h033, 9'h044};
        s = a + 2;
        check_stream(2, s, 5);
        n_done = 0; prev = -1; gaps_ok = 1;
        for (int tt = a; tt <= s + 5*160 + 4; tt++) begin
            if (hd[2][tt] === 1'b1) begin
                if (prev >= 0 && tt - prev != 160) gaps_ok = 0;
                prev = tt;
                n_done++;
            end
        end
        chk("ovf_done_count", 32'(n_done), 32'd5);
        chk("ovf_done_spacing", 32'(gaps_ok), 32'd1);
        count_window(2, s, s + 5*160 - 1, n_act, n);
        chk("ovf_active_continuous", 32'(n_act), 32'd800);
        wait_idle(2);

        // Write on the same edge as a back-to-back pop with two words waiting
        wq = {9'h081, 9'h042, 9'h0C3, 9'h024};
        write_word(2, wq[0], a);
        write_word(2, wq[1], dummy);
        write_word(2, wq[2], dummy);
        wait_to(a + 160);
        chk("wrpop_cnt_before", 32'(cnt2), 32'd2);
        write_word(2, wq[3], b);
        chk("wrpop_edge", 32'(b), 32'(a + 161));
        chk("wrpop_cnt_after", 32'(cnt2), 32'd2);
        check_stream(2, a + 2, 4);
        wait_idle(2);

        // Reset in the middle of data bit 3 with words still queued
        write_word(2, 9'h0F0, a);
        write_word(2, 9'h00F, dummy);
        write_word(2, 9'h0AA, dummy);
        s = a + 2;
        wait_to(s + 16*4 + 7);
        #2 rst_n[2] = 1'b0;
        #1;
        chk("abort_serial", 32'(ser2), 32'd1);
        chk("abort_cnt", 32'(cnt2), 32'd0);
        chk("abort_active", 32'(act2), 32'd0);
        chk("abort_ready", 32'(rdy2), 32'd1);
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b1;
        wq = {9'h03C};
        write_word(2, 9'h03C, b);
        check_stream(2, b + 2, 1);
        n = 0;
        for (int tt = a; tt <= b + 1; tt++) if (hd[2][tt] !== 1'b0) n++;
        chk("abort_no_done", 32'(n), 32'd0);
        wait_idle(2);

        // Random bursts, later words arriving while the first frame is on the line
        for (int k = 0; k < 3; k++) begin
            mask = (db[k] == 7) ? 9'h07F : 9'h0FF;
            for (int r = 0; r < 3; r++) begin
                n = int'($urandom_range(1, 4));
                wq.delete();
                for (int i = 0; i < n; i++) begin
                    w = 9'($urandom) & mask;
                    wq.push_back(w);
                end
                write_word(k, wq[0], a);
                for (int i = 1; i < n; i++) begin
                    t = int'($urandom_range(0, 25));
                    repeat (t) @(negedge clk);
                    write_word(k, wq[i], dummy);
                end
                check_stream(k, a + 2, n);
                wait_idle(k);
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit; legal range 4..511.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-006 SHALL have port i_Clock, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have port i_Rst_L, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port i_Tx_DV, input, 1, write strobe for i_Tx_Byte.
REQ-009 SHALL have port i_Tx_Byte, input, DATA_BITS, word to transmit.
REQ-010 SHALL have port o_Tx_Ready, output, 1, high when FIFO not full.
REQ-011 SHALL have port o_Fifo_Count, output, log2(FIFO_DEPTH)+1, words queued and not yet popped.
REQ-012 SHALL have port o_Overflow, output, 1, one-cycle pulse when a write is refused.
REQ-013 SHALL have port o_Tx_Active, output, 1, high while any frame bit is on the line.
REQ-014 SHALL have port o_Tx_Serial, output, 1, registered serial line; idle high.
REQ-015 SHALL have port o_Tx_Done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-016 SHALL accept a write on an edge where i_Tx_DV=1 and o_Tx_Ready=1; o_Tx_Ready SHALL reflect the count before that edge, so a full FIFO refuses the write even if a pop occurs in the same cycle.
REQ-017 SHALL pulse o_Overflow the cycle after a refused write, drop that word and leave the FIFO unchanged.
REQ-018 SHALL use an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with a non-empty FIFO, SHALL pop the head word into the shift register and enter START. o_Tx_Serial SHALL fall two clocks after the edge that accepted the write into an empty FIFO.
REQ-020 SHALL hold each bit on o_Tx_Serial for exactly CLKS_PER_BIT clocks.
REQ-021 SHALL send bits in this order: start bit 0, then DATA_BITS bits LSB first, then the parity bit (only when PARITY_MODE≠0), then STOP_BITS stop bits of value 1.
REQ-022 Parity SHALL be the XOR of all data bits for even mode and its inverse for odd mode, so the count of ones in data plus parity is even or odd respectively.
REQ-023 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) clocks, where P=1 if parity is enabled.
REQ-024 In the last clock of the final stop bit, SHALL pulse o_Tx_Done for one cycle. If the FIFO is non-empty, SHALL pop and enter START so the next start bit follows with zero idle clocks; otherwise SHALL enter IDLE.
REQ-025 o_Tx_Active SHALL go high with the first start-bit clock and go low after the final stop-bit clock; it SHALL stay high across back-to-back frames.
REQ-026 SHALL update o_Fifo_Count on every accepted write (+1) and every pop (-1); a simultaneous write and pop SHALL leave it unchanged.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Writes arriving mid-frame SHALL NOT disturb the frame in progress.
REQ-029 An illegal FSM state SHALL return to IDLE with the line high.

Reset
REQ-030 While i_Rst_L=0, SHALL asynchronously force: FSM to IDLE; o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Overflow=0; o_Fifo_Count=0; o_Tx_Ready=1; FIFO pointers=0; bit and clock counters=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, drive the line high and discard all queued words; no o_Tx_Done pulse SHALL occur for the aborted frame.
REQ-032 After reset release, the first rising edge SHALL be able to accept a write.

Verification
REQ-033 Bench SHALL cover: parameters 16/8/even/1; write 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,0,1, each bit 16 clocks (176 total), one o_Tx_Done pulse.
REQ-034 Bench SHALL cover: parameters 16/7/odd/2; write 0x00 -> 7 zero data bits, parity 1, line high for 32 clocks, frame 176 clocks.
REQ-035 Bench SHALL cover: FIFO_DEPTH=4, no parity; five writes on consecutive cycles -> four accepted, fifth refused with o_Overflow pulse, o_Tx_Ready low while the count is 4. Four contiguous frames with o_Tx_Done pulses 160 clocks apart and o_Tx_Active continuously high.
REQ-036 Bench SHALL cover: i_Rst_L low during data bit 3 -> o_Tx_Serial=1 the same cycle, count 0, no o_Tx_Done. After release, a write of 0x3C transmits correctly.
REQ-037 Bench SHALL cover: write and pop on the same edge with count 2 -> count stays 2.
